// File: rtl/act_skew_feeder_if.sv
// Control, unified-buffer row and skewed-activation signals of the activation skew feeder.
// act_zp is present only when ACT_ZERO_POINT_EN is defined.
interface act_skew_feeder_if #(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int ROW_W  = 256
);
   logic                start;
   logic [7:0]          rows;
   logic                advance;
   logic                in_valid;
   logic [ROW_W-1:0]    in_data;
   logic                in_ready;
   logic [N*DATA_W-1:0] act_out;
   logic [N-1:0]        act_valid;
   logic                busy;
   logic                done;
`ifdef ACT_ZERO_POINT_EN
   logic [DATA_W-1:0]   act_zp;

   modport master (output start, rows, advance, in_valid, in_data, act_zp,
                   input  in_ready, act_out, act_valid, busy, done);
   modport slave  (input  start, rows, advance, in_valid, in_data, act_zp,
                   output in_ready, act_out, act_valid, busy, done);
`else
   modport master (output start, rows, advance, in_valid, in_data,
                   input  in_ready, act_out, act_valid, busy, done);
   modport slave  (input  start, rows, advance, in_valid, in_data,
                   output in_ready, act_out, act_valid, busy, done);
`endif
endinterface

// File: rtl/act_skew_feeder.sv
// Streams unified-buffer rows into the systolic array as a diagonal wavefront (lane k delayed k cycles).
// Optional ACT_ZERO_POINT_EN: subtract a per-pass zero point from each lane and saturate to signed DATA_W.
module act_skew_feeder #(
   parameter int N      = 3,
   parameter int DATA_W = 8,
   parameter int ROW_W  = 256
) (
   input logic              clk,
   input logic              rst,
   act_skew_feeder_if.slave bus
);
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, FINISH} state_t;

   state_t              state, state_n;
   logic [7:0]          rem, rem_n;
   logic [CNT_W-1:0]    drn, drn_n;
   logic                accept;
   logic [N*DATA_W-1:0] dat_in;
   logic [N*DATA_W-1:0] dat_p [N];
   logic [N-1:0]        vld_p [N];

`ifdef ACT_ZERO_POINT_EN
   localparam logic signed [DATA_W+1:0] SAT_MAX = (DATA_W+2)'((1 << (DATA_W-1)) - 1);
   localparam logic signed [DATA_W+1:0] SAT_MIN = ~SAT_MAX;

   logic [DATA_W-1:0] zp;

   function automatic logic [DATA_W-1:0] sub_sat(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
      logic signed [DATA_W+1:0] diff;
      diff = $signed({2'b00, a}) - $signed({2'b00, b});
      if (diff > SAT_MAX)
         diff = SAT_MAX;
      else if (diff < SAT_MIN)
         diff = SAT_MIN;
      return diff[DATA_W-1:0];
   endfunction

   always_ff @(posedge clk) begin
      if (rst)
         zp <= '0;
      else if (bus.advance && bus.start && state == IDLE)
         zp <= bus.act_zp;
   end
`endif

   assign bus.in_ready = (state == STREAM) && bus.advance && (rem != 8'd0);
   assign accept       = bus.in_valid && bus.in_ready;
   assign bus.busy     = (state == STREAM) || (state == DRAIN);
   assign bus.done     = (state == FINISH) && bus.advance;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         rem   <= '0;
         drn   <= '0;
      end else begin
         state <= state_n;
         rem   <= rem_n;
         drn   <= drn_n;
      end
   end

   // A stalled cycle keeps every control register, so done is deferred with it.
   always_comb begin
      state_n = state;
      rem_n   = rem;
      drn_n   = drn;
      if (bus.advance) begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (bus.rows != 8'd0) begin
                     state_n = STREAM;
                     rem_n   = bus.rows;
                  end else begin
                     state_n = FINISH;
                  end
               end
            end
            STREAM: begin
               if (accept) begin
                  rem_n = rem - 8'd1;
                  if (rem == 8'd1) begin
                     if (N == 1) begin
                        state_n = FINISH;
                     end else begin
                        state_n = DRAIN;
                        drn_n   = CNT_W'(N - 1);
                     end
                  end
               end
            end
            DRAIN: begin
               if (drn == '0)
                  state_n = FINISH;
               else
                  drn_n = drn - 1'b1;
            end
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_comb begin
      dat_in = '0;
      for (int k = 0; k < N; k++) begin
`ifdef ACT_ZERO_POINT_EN
         dat_in[k*DATA_W +: DATA_W] = sub_sat(bus.in_data[k*DATA_W +: DATA_W], zp);
`else
         dat_in[k*DATA_W +: DATA_W] = bus.in_data[k*DATA_W +: DATA_W];
`endif
      end
   end

   // Stage 0: accepted row or bubble; stages 1..N-1 form the per-lane delay lines.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < N; s++) begin
            dat_p[s] <= '0;
            vld_p[s] <= '0;
         end
      end else if (bus.advance) begin
         dat_p[0] <= accept ? dat_in : '0;
         vld_p[0] <= {N{accept}};
         for (int s = 1; s < N; s++) begin
            dat_p[s] <= dat_p[s-1];
            vld_p[s] <= vld_p[s-1];
         end
      end
   end

   for (genvar k = 0; k < N; k++) begin : g_lane
      assign bus.act_out[k*DATA_W +: DATA_W] = dat_p[k][k*DATA_W +: DATA_W];
      assign bus.act_valid[k]                = vld_p[k][k];
   end

   if (ROW_W > N*DATA_W) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^bus.in_data[ROW_W-1:N*DATA_W];
   end
endmodule

// File: tb/tb_act_skew_feeder.sv
// Directed bench for act_skew_feeder: reset, skew timing, bubbles, stalls, edge cases, zero point.
module tb_act_skew_feeder;
   localparam int N      = 3;
   localparam int DATA_W = 8;
   localparam int ROW_W  = 256;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   act_skew_feeder_if #(.N(N), .DATA_W(DATA_W), .ROW_W(ROW_W)) bus ();

   act_skew_feeder #(.N(N), .DATA_W(DATA_W), .ROW_W(ROW_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      checks++;
      assert (obs_v === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs_v, exp_v);
      end
   endtask

   task automatic obs(input string tag, input logic [23:0] a, input logic [2:0] v,
                      input logic b, input logic d);
      chk({tag, ".act"},   32'(bus.act_out),   32'(a));
      chk({tag, ".vld"},   32'(bus.act_valid), 32'(v));
      chk({tag, ".busy"},  32'(bus.busy),      32'(b));
      chk({tag, ".done"},  32'(bus.done),      32'(d));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.rows = 8'd0;
      bus.advance = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data = '0;
`ifdef ACT_ZERO_POINT_EN
      bus.act_zp = '0;
`endif
      repeat (3) tick();
      rst = 1'b0;
      bus.advance = 1'b1;
      #1 obs("rst", 24'h0, 3'b000, 1'b0, 1'b0);
      chk("rst.ready", 32'(bus.in_ready), 32'd0);
      tick();

      // basic skew, rows=2, start retried while busy
      bus.start = 1'b1; bus.rows = 8'd2; bus.in_valid = 1'b1; bus.in_data = 256'h030201;
      #1 chk("b.s.ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.start = 1'b0;
      #1 chk("b.c0.ready", 32'(bus.in_ready), 32'd1);
      obs("b.c0", 24'h0, 3'b000, 1'b1, 1'b0);
      tick();
      bus.in_data = 256'h131211;
      #1 obs("b.c1", 24'h000001, 3'b001, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0; bus.start = 1'b1; bus.rows = 8'd5;
      #1 chk("b.c2.ready", 32'(bus.in_ready), 32'd0);
      obs("b.c2", 24'h000211, 3'b011, 1'b1, 1'b0);
      tick();
      bus.start = 1'b0;
      #1 obs("b.c3", 24'h031200, 3'b110, 1'b1, 1'b0);
      tick();
      #1 obs("b.c4", 24'h130000, 3'b100, 1'b1, 1'b0);
      tick();
      #1 obs("b.c5", 24'h0, 3'b000, 1'b0, 1'b1);
      tick();
      #1 obs("b.c6", 24'h0, 3'b000, 1'b0, 1'b0);
      tick();

      // one-cycle bubble between rows
      bus.start = 1'b1; bus.rows = 8'd2; bus.in_valid = 1'b1; bus.in_data = 256'h332211;
      tick();
      bus.start = 1'b0;
      #1 chk("u.c0.ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      #1 chk("u.c1.ready", 32'(bus.in_ready), 32'd1);
      obs("u.c1", 24'h000011, 3'b001, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b1; bus.in_data = 256'h665544;
      #1 obs("u.c2", 24'h002200, 3'b010, 1'b1, 1'b0);
      tick();
      bus.in_valid = 1'b0;
      #1 obs("u.c3", 24'h330044, 3'b101, 1'b1, 1'b0);
      tick();
      #1 obs("u.c4", 24'h005500, 3'b010, 1'b1, 1'b0);
      tick();
      #1 obs("u.c5", 24'h660000, 3'b100, 1'b1, 1'b0);
      tick();
      #1 obs("u.c6", 24'h0, 3'b000, 1'b0, 1'b1);
      tick();
      #1 obs("u.c7", 24'h0, 3'b000, 1'b0, 1'b0);
      tick();

      // stall in STREAM (one cycle) and mid-DRAIN (two cycles)
      bus.start = 1'b1; bus.rows = 8'd1; bus.in_valid = 1'b1; bus.in_data = 256'h0C0B0A;
      tick();
      bus.start = 1'b0; bus.advance = 1'b0;
      #1 chk("s.x.ready", 32'(bus.in_ready), 32'd0);
      obs("s.x", 24'h0, 3'b000, 1'b1, 1'b0);
      tick();
      bus.advance = 1'b1;
      #1 chk("s.c0.ready", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      #1 obs("s.c1", 24'h00000A, 3'b001, 1'b1, 1'b0);
      tick();
      bus.advance = 1'b0;
      #1 obs("s.c2", 24'h000B00, 3'b010, 1'b1, 1'b0);
      tick();
      #1 obs("s.c3", 24'h000B00, 3'b010, 1'b1, 1'b0);
      chk("s.c3.ready", 32'(bus.in_ready), 32'd0);
      tick();
      bus.advance = 1'b1;
      #1 obs("s.c4", 24'h000B00, 3'b010, 1'b1, 1'b0);
      tick();
      #1 obs("s.c5", 24'h0C0000, 3'b100, 1'b1, 1'b0);
      tick();
      #1 obs("s.c6", 24'h0, 3'b000, 1'b0, 1'b1);
      tick();
      #1 obs("s.c7", 24'h0, 3'b000, 1'b0, 1'b0);
      tick();

      // rows=0 goes straight to FINISH
      bus.start = 1'b1; bus.rows = 8'd0;
      tick();
      bus.start = 1'b0;
      #1 obs("z.f", 24'h0, 3'b000, 1'b0, 1'b1);
      tick();
      #1 obs("z.n", 24'h0, 3'b000, 1'b0, 1'b0);
      tick();

      // reset in the middle of STREAM
      bus.start = 1'b1; bus.rows = 8'd3; bus.in_valid = 1'b1; bus.in_data = 256'h030201;
      tick();
      bus.start = 1'b0;
      tick();
      bus.in_data = 256'h131211;
      #1 obs("r.c1", 24'h000001, 3'b001, 1'b1, 1'b0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1 obs("r.c3", 24'h0, 3'b000, 1'b0, 1'b0);
      chk("r.c3.ready", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1 obs("r.after", 24'h0, 3'b000, 1'b0, 1'b0);
      end
      tick();

      // zero point: lanes {0xFF,0x80,0x00} with act_zp=0x80
      bus.start = 1'b1; bus.rows = 8'd1; bus.in_valid = 1'b1; bus.in_data = 256'hFF8000;
`ifdef ACT_ZERO_POINT_EN
      bus.act_zp = 8'h80;
`endif
      tick();
      bus.start = 1'b0;
      tick();
      bus.in_valid = 1'b0;
`ifdef ACT_ZERO_POINT_EN
      #1 obs("zp.c1", 24'h000080, 3'b001, 1'b1, 1'b0);
      tick();
      #1 obs("zp.c2", 24'h000000, 3'b010, 1'b1, 1'b0);
      tick();
      #1 obs("zp.c3", 24'h7F0000, 3'b100, 1'b1, 1'b0);
`else
      #1 obs("zp.c1", 24'h000000, 3'b001, 1'b1, 1'b0);
      tick();
      #1 obs("zp.c2", 24'h008000, 3'b010, 1'b1, 1'b0);
      tick();
      #1 obs("zp.c3", 24'hFF0000, 3'b100, 1'b1, 1'b0);
`endif
      tick();
      #1 obs("zp.c4", 24'h0, 3'b000, 1'b0, 1'b1);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
